// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin arbiter that lets four requesters share one WIDTH-bit
//   register. A granted requester either writes its wdata slice or only
//   performs a read-only access. Each completed access emits a one-cycle
//   done pulse, and the pointer then moves past the winner.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset
//   req    : [3:0] level-held requests, bit i = requester i
//   wr     : [3:0] per-requester operation, 1 = write, 0 = read-only
//   wdata  : [4*WIDTH-1:0] write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    : [3:0] registered one-hot grant
//   done   : registered one-cycle completion pulse
//   busy   : high whenever the FSM is not in IDLE
//   q      : shared register value
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for requests; arbitrates from ptr on any req
// SERVE   | grant held; commits access next edge unless req withdrawn
// RELEASE | done pulse cycle; always returns to IDLE
module reg_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [3:0]         wr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic               done,
  output logic               busy,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       sel, sel_n;
  logic [3:0]       gnt_n;
  logic             done_n;
  logic [WIDTH-1:0] q_n;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;

  // First set request found when scanning cyclically upward from ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = '0;
    done_n  = 1'b0;
    q_n     = q;
    case (state)
      IDLE: begin
        if (found) begin
          sel_n   = win;
          gnt_n   = 4'b0001 << win;
          state_n = SERVE;
        end
      end
      SERVE: begin
        // Only the granted requester's own lines matter here; a dropped
        // req abandons the access without moving the pointer.
        if (req[sel]) begin
          if (wr[sel]) q_n = wdata[sel*WIDTH +: WIDTH];
          done_n  = 1'b1;
          ptr_n   = sel + 2'd1;
          state_n = RELEASE;
        end else begin
          state_n = IDLE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      done  <= 1'b0;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      done  <= done_n;
      q     <= q_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
//   Driver issues transactions and pushes predicted grants/completions
//   from a reference model into queues; a monitor pops and compares
//   whenever the DUT shows a grant or a done pulse.
module tb_reg_share_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic [3:0]         req;
  logic [3:0]         wr;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         gnt;
  logic               done;
  logic               busy;
  logic [WIDTH-1:0]   q;

  reg_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .wdata (wdata),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       g;
    logic [WIDTH-1:0] qv;
  } gnt_exp_t;

  gnt_exp_t         gnt_q[$];
  logic [WIDTH-1:0] done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int               m_ptr = 0;
  logic [WIDTH-1:0] m_q   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // monitor
  initial begin
    gnt_exp_t e;
    forever begin
      @(negedge clk);
      chk("busy_vs_outputs", {31'd0, busy}, {31'd0, (gnt != 0) || done});
      chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (gnt != 0) begin
        chk("done_with_gnt", {31'd0, done}, 32'd0);
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt", {28'd0, gnt}, {28'd0, e.g});
          chk("q_at_gnt", {24'd0, q}, {24'd0, e.qv});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          chk("q_at_done", {24'd0, q}, {24'd0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b1111;
    wr    = 4'b1111;
    wdata = $urandom;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_q",    {24'd0, q}, 32'd0);
    m_ptr = 0;
    m_q   = '0;
    req   = 4'b0000;
    reset = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE. mode: 0 complete, 1 withdraw,
  // 2 reset during SERVE.
  task automatic txn(input logic [3:0] r, input logic [3:0] w,
                     input logic [4*WIDTH-1:0] d, input int mode);
    int win;
    gnt_exp_t e;
    req = r; wr = w; wdata = d;
    win = model_winner(r);
    if (win < 0) begin
      @(posedge clk); @(negedge clk);
      chk("idle_no_gnt",  {28'd0, gnt}, 32'd0);
      chk("idle_no_busy", {31'd0, busy}, 32'd0);
      return;
    end
    e.g  = 4'(1 << win);
    e.qv = m_q;
    gnt_q.push_back(e);
    @(posedge clk); @(negedge clk);
    // now in SERVE: other requesters' lines and wdata slices are noise
    for (int i = 0; i < 4; i++) begin
      if (i != win) begin
        req[i] = 1'($urandom);
        wr[i]  = 1'($urandom);
        wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    if (mode == 2) begin
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_serve_q",    {24'd0, q}, 32'd0);
      chk("rst_serve_gnt",  {28'd0, gnt}, 32'd0);
      chk("rst_serve_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      req   = 4'b0000;
      m_ptr = 0;
      m_q   = '0;
      return;
    end
    req[win] = (mode == 0);
    if (mode == 0) begin
      if (w[win]) m_q = d[win*WIDTH +: WIDTH];
      m_ptr = (win + 1) % 4;
      done_q.push_back(m_q);
    end
    @(posedge clk); @(negedge clk);
    if (mode == 0) begin
      // RELEASE: everything on the inputs is ignored
      req = 4'($urandom); wr = 4'($urandom); wdata = $urandom;
      @(posedge clk); @(negedge clk);
    end
    chk("q_after_txn", {24'd0, q}, {24'd0, m_q});
  endtask

  initial begin
    reset = 1'b0; req = '0; wr = '0; wdata = '0;
    @(negedge clk);
    do_reset();

    // single write from requester 2
    txn(4'b0100, 4'b0100, 32'h00A5_0000, 0);
    chk("single_q", {24'd0, q}, 32'h0000_00A5);

    // round robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++)
      txn(4'b1111, 4'b1111, 32'h4332_2110, 0);
    chk("rr_q", {24'd0, q}, 32'h0000_0010);

    // read-only: load 5A via requester 1, then read-only access by 0
    txn(4'b0010, 4'b0010, 32'h0000_5A00, 0);
    txn(4'b0001, 4'b0000, 32'h0000_00FF, 0);
    chk("ro_q", {24'd0, q}, 32'h0000_005A);

    // withdrawal keeps ptr at 1, so the next full request goes to 1
    txn(4'b0001, 4'b0001, 32'h0000_0077, 1);
    txn(4'b1111, 4'b0000, 32'h0, 0);

    // reset during SERVE
    txn(4'b0001, 4'b0001, 32'h0000_00CC, 0);
    txn(4'b0001, 4'b0001, 32'h0000_00CC, 2);
    txn(4'b0000, 4'b1111, 32'hFFFF_FFFF, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int pick;
      int mode;
      pick = $urandom_range(0, 19);
      mode = (pick < 3) ? 1 : (pick == 3) ? 2 : 0;
      txn(4'($urandom), 4'($urandom), $urandom, mode);
    end

    req = '0;
    repeat (3) @(negedge clk);
    chk("gnt_q_drained",  gnt_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
